// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed or unsigned
// operands chosen per transaction, valid/ready handshakes on both sides.
module booth_mult_seq #(
    parameter int WA = 16,
    parameter int WB = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WA-1:0]      A,
    input  logic [WB-1:0]      B,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WA+WB-1:0]   P,
    output logic               busy
);
    localparam int WBX  = ((WB + 2) / 2) * 2;
    localparam int ITER = WBX / 2;
    localparam int ACCW = WA + WBX + 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg, state_next;
    logic [WA+1:0]       a_reg;
    logic [WBX:0]        b_reg;      // {Bx, 1'b0}: bit 0 supplies Bx[-1] for digit 0
    logic [ACCW-1:0]     acc_reg, acc_next, ax_full, pp;
    logic [CW-1:0]       cnt_reg;
    logic [WA+WB-1:0]    p_reg;
    logic                last_digit, accept;
    logic [WA+1:0]       a_ext;
    logic [WBX-1:0]      b_ext;

    assign last_digit = (cnt_reg == CW'(ITER - 1));
    assign accept     = (state_reg == IDLE) && in_valid;
    assign a_ext      = {{2{signed_mode & A[WA-1]}}, A};
    assign b_ext      = {{(WBX-WB){signed_mode & B[WB-1]}}, B};

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign P          = p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = CALC;
            CALC:    if (last_digit) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Partial product for the current digit, taken from the low triplet of the shifting B copy.
    always_comb begin
        ax_full = {{WBX{a_reg[WA+1]}}, a_reg};
        pp      = '0;
        case (b_reg[2:0])
            3'b001, 3'b010: pp = ax_full;
            3'b011:         pp = ax_full << 1;
            3'b100:         pp = -(ax_full << 1);
            3'b101, 3'b110: pp = -ax_full;
            default:        pp = '0;
        endcase
        acc_next = acc_reg + (pp << {cnt_reg, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
            p_reg   <= '0;
        end else if (accept) begin
            a_reg   <= a_ext;
            b_reg   <= {b_ext, 1'b0};
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (state_reg == CALC) begin
            acc_reg <= acc_next;
            b_reg   <= b_reg >> 2;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_digit) begin
                p_reg <= acc_next[WA+WB-1:0];
            end
        end
    end
endmodule
